// File: rtl/segment_scan_decoder.sv
// Recovers four BCD digits, blank flags and a frame strobe from a muxed active-low 7-seg bus; SEG_BIN_OUT_EN adds binary mins/secs.
// Latency: 2 sync cycles + STABLE_CYC dwell cycles from a stable bus change to registered outputs.
// Backpressure: none; a passive monitor that samples every cycle.
module segment_scan_decoder #(
    parameter int unsigned STABLE_CYC = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  anode,
    input  logic [6:0]  segment,
    input  logic        clr_err,
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic [3:0]  blank,
    output logic        frame_done,
    output logic        scan_err
`ifdef SEG_BIN_OUT_EN
    ,
    output logic [5:0]  mins,
    output logic [5:0]  secs,
    output logic        bin_valid
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(STABLE_CYC);
    localparam logic [CNT_W-1:0] CNT_COMMIT = CNT_W'(STABLE_CYC - 2);

    logic [10:0]      sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      digits_q, digits_d;
    logic [3:0]       digit_valid_q, digit_valid_d;
    logic [3:0]       blank_q, blank_d;
    logic [3:0]       seen_q, seen_d;
    logic             frame_done_q, frame_done_d;
    logic             scan_err_q, scan_err_d;
    logic             commit, err_set;
    logic [3:0]       low, seen_mask;
    logic [4:0]       dec;

    // Returns {match, value} for the ten active-low numeral patterns.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        case (s)
            7'h40:   seg_decode = {1'b1, 4'd0};
            7'h79:   seg_decode = {1'b1, 4'd1};
            7'h24:   seg_decode = {1'b1, 4'd2};
            7'h30:   seg_decode = {1'b1, 4'd3};
            7'h19:   seg_decode = {1'b1, 4'd4};
            7'h12:   seg_decode = {1'b1, 4'd5};
            7'h02:   seg_decode = {1'b1, 4'd6};
            7'h78:   seg_decode = {1'b1, 4'd7};
            7'h00:   seg_decode = {1'b1, 4'd8};
            7'h10:   seg_decode = {1'b1, 4'd9};
            default: seg_decode = 5'd0;
        endcase
    endfunction

`ifdef SEG_BIN_OUT_EN
    logic [5:0] mins_q, mins_d, secs_q, secs_d;
    logic       bin_valid_q, bin_valid_d, tens_bad;
`endif

    always_comb begin
        sync1_d       = {anode, segment};
        sync2_d       = sync1_q;
        prev_d        = sync2_q;
        cnt_d         = cnt_q;
        commit        = 1'b0;
        err_set       = 1'b0;
        digits_d      = digits_q;
        digit_valid_d = digit_valid_q;
        blank_d       = blank_q;
        seen_d        = seen_q;
        frame_done_d  = 1'b0;
        low           = ~sync2_q[10:7];
        seen_mask     = seen_q | low;
        dec           = seg_decode(sync2_q[6:0]);

        if (sync2_q != prev_q) begin
            cnt_d = '0;
        end else begin
            if (cnt_q != CNT_MAX)
                cnt_d = cnt_q + CNT_W'(1);
            commit = (cnt_q == CNT_COMMIT);
        end

        // Idle gaps (all anodes off) commit as a no-op.
        if (commit && low != 4'h0) begin
            if ((low & 4'(low - 4'd1)) != 4'h0) begin
                err_set = 1'b1;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (low[i]) begin
                        if (dec[4]) begin
                            digits_d[4*i +: 4] = dec[3:0];
                            digit_valid_d[i]   = 1'b1;
                            blank_d[i]         = 1'b0;
                        end else if (sync2_q[6:0] == 7'h7F) begin
                            digit_valid_d[i] = 1'b0;
                            blank_d[i]       = 1'b1;
                        end else begin
                            err_set          = 1'b1;
                            digit_valid_d[i] = 1'b0;
                            blank_d[i]       = 1'b0;
                        end
                    end
                end
                if (seen_mask == 4'hF) begin
                    frame_done_d = 1'b1;
                    seen_d       = 4'h0;
                end else begin
                    seen_d = seen_mask;
                end
            end
        end

`ifdef SEG_BIN_OUT_EN
        mins_d      = mins_q;
        secs_d      = secs_q;
        bin_valid_d = bin_valid_q;
        tens_bad    = (digits_q[7:4] > 4'd5) || (digits_q[15:12] > 4'd5);
        if (frame_done_q) begin
            if (tens_bad)
                err_set = 1'b1;
            if ((&digit_valid_q) && !tens_bad) begin
                secs_d      = 6'(digits_q[7:4]) * 6'd10 + 6'(digits_q[3:0]);
                mins_d      = 6'(digits_q[15:12]) * 6'd10 + 6'(digits_q[11:8]);
                bin_valid_d = 1'b1;
            end else begin
                bin_valid_d = 1'b0;
            end
        end
`endif

        // A new error in the same cycle as clr_err keeps the flag set.
        scan_err_d = (scan_err_q & ~clr_err) | err_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= '1;
            sync2_q       <= '1;
            prev_q        <= '1;
            cnt_q         <= '0;
            digits_q      <= '0;
            digit_valid_q <= '0;
            blank_q       <= '0;
            seen_q        <= '0;
            frame_done_q  <= 1'b0;
            scan_err_q    <= 1'b0;
`ifdef SEG_BIN_OUT_EN
            mins_q        <= '0;
            secs_q        <= '0;
            bin_valid_q   <= 1'b0;
`endif
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            prev_q        <= prev_d;
            cnt_q         <= cnt_d;
            digits_q      <= digits_d;
            digit_valid_q <= digit_valid_d;
            blank_q       <= blank_d;
            seen_q        <= seen_d;
            frame_done_q  <= frame_done_d;
            scan_err_q    <= scan_err_d;
`ifdef SEG_BIN_OUT_EN
            mins_q        <= mins_d;
            secs_q        <= secs_d;
            bin_valid_q   <= bin_valid_d;
`endif
        end
    end

    assign digits      = digits_q;
    assign digit_valid = digit_valid_q;
    assign blank       = blank_q;
    assign frame_done  = frame_done_q;
    assign scan_err    = scan_err_q;
`ifdef SEG_BIN_OUT_EN
    assign mins        = mins_q;
    assign secs        = secs_q;
    assign bin_valid   = bin_valid_q;
`endif

endmodule

// File: tb/tb_segment_scan_decoder.sv
// Bench for segment_scan_decoder: directed test-plan steps then randomized rotations, checked against a bus-history reference model.
// Latency: model commits a run of STABLE_CYC equal bus values 2+STABLE_CYC edges after the run starts.
// Backpressure: not applicable.
module tb_segment_scan_decoder;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  anode = 4'hF;
    logic [6:0]  segment = 7'h7F;
    logic        clr_err = 1'b0;
    logic [15:0] digits;
    logic [3:0]  digit_valid, blank;
    logic        frame_done, scan_err;
`ifdef SEG_BIN_OUT_EN
    logic [5:0]  mins, secs;
    logic        bin_valid;
    logic [5:0]  m_mins, m_secs;
    bit          m_binv;
`endif

    segment_scan_decoder #(.STABLE_CYC(S), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .anode(anode), .segment(segment), .clr_err(clr_err),
        .digits(digits), .digit_valid(digit_valid), .blank(blank),
        .frame_done(frame_done), .scan_err(scan_err)
`ifdef SEG_BIN_OUT_EN
        , .mins(mins), .secs(secs), .bin_valid(bin_valid)
`endif
    );

    always #5 clk = ~clk;

    logic [6:0]  seg_code [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic [3:0]  an_sel [4]    = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0]  t0235 [4]     = '{7'h12, 7'h30, 7'h24, 7'h40};

    // Reference state: bus history (newest first) plus the visible outputs.
    logic [10:0] hist[$];
    logic [3:0]  m_dig [4];
    logic [3:0]  m_val, m_blank, m_seen;
    bit          m_fd, m_err;
    int          total = 0, bad = 0, fd_cnt = 0, base;

    function automatic int seg_lookup(input logic [6:0] s);
        for (int k = 0; k < 10; k++)
            if (seg_code[k] == s) return k;
        return -1;
    endfunction

    task automatic model_reset();
        hist.delete();
        repeat (S + 3) hist.push_back(11'h7FF);
        for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
        m_val = 0; m_blank = 0; m_seen = 0; m_fd = 0; m_err = 0;
`ifdef SEG_BIN_OUT_EN
        m_mins = 0; m_secs = 0; m_binv = 0;
`endif
    endtask

    task automatic model_edge(input logic [3:0] an, input logic [6:0] sg, input bit clr);
        logic [10:0] v;
        bit commit, nerr, pfd;
        int nlow, idx, k;
        hist.push_front({an, sg});
        void'(hist.pop_back());
        v = hist[2];
        commit = 1;
        for (int j = 3; j <= S + 1; j++)
            if (hist[j] != v) commit = 0;
        if (hist[S + 2] == v) commit = 0;
        pfd = m_fd;
        m_fd = 0;
        nerr = 0;
`ifdef SEG_BIN_OUT_EN
        if (pfd) begin
            if (m_dig[1] > 5 || m_dig[3] > 5) nerr = 1;
            if (m_val == 4'hF && m_dig[1] <= 5 && m_dig[3] <= 5) begin
                m_secs = 6'(m_dig[1] * 10 + m_dig[0]);
                m_mins = 6'(m_dig[3] * 10 + m_dig[2]);
                m_binv = 1;
            end else begin
                m_binv = 0;
            end
        end
`else
        if (pfd) nerr = 0;
`endif
        if (commit && v[10:7] != 4'hF) begin
            nlow = 0; idx = 0;
            for (int i = 0; i < 4; i++)
                if (!v[7 + i]) begin nlow++; idx = i; end
            if (nlow == 1) begin
                m_seen[idx] = 1;
                k = seg_lookup(v[6:0]);
                if (k >= 0) begin
                    m_dig[idx] = 4'(k); m_val[idx] = 1; m_blank[idx] = 0;
                end else if (v[6:0] == 7'h7F) begin
                    m_val[idx] = 0; m_blank[idx] = 1;
                end else begin
                    nerr = 1; m_val[idx] = 0; m_blank[idx] = 0;
                end
                if (m_seen == 4'hF) begin m_fd = 1; m_seen = 0; end
            end else begin
                nerr = 1;
            end
        end
        m_err = nerr ? 1'b1 : (clr ? 1'b0 : m_err);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("digits", 32'(digits), 32'({m_dig[3], m_dig[2], m_dig[1], m_dig[0]}));
        check("digit_valid", 32'(digit_valid), 32'(m_val));
        check("blank", 32'(blank), 32'(m_blank));
        check("frame_done", 32'(frame_done), 32'(m_fd));
        check("scan_err", 32'(scan_err), 32'(m_err));
`ifdef SEG_BIN_OUT_EN
        check("mins", 32'(mins), 32'(m_mins));
        check("secs", 32'(secs), 32'(m_secs));
        check("bin_valid", 32'(bin_valid), 32'(m_binv));
`endif
    endtask

    task automatic step(input logic [3:0] an, input logic [6:0] sg, input bit clr);
        anode = an; segment = sg; clr_err = clr;
        @(posedge clk);
        #1;
        model_edge(an, sg, clr);
        if (frame_done === 1'b1) fd_cnt++;
        compare_all();
    endtask

    task automatic hold(input logic [3:0] an, input logic [6:0] sg, input int n);
        repeat (n) step(an, sg, 0);
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("rst_digits_zero", 32'(digits), 32'h0);
        @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] an;
        logic [6:0] sg;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;

        // "02:35" rotation twice
        base = fd_cnt;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++) hold(an_sel[i], t0235[i], 8);
        check("rot_digits", 32'(digits), 32'h0235);
        check("rot_valid", 32'(digit_valid), 32'hF);
        check("rot_fd_count", 32'(fd_cnt - base), 32'd2);
`ifdef SEG_BIN_OUT_EN
        hold(4'hF, 7'h7F, 2);
        check("rot_mins", 32'(mins), 32'd2);
        check("rot_secs", 32'(secs), 32'd35);
        check("rot_binv", 32'(bin_valid), 32'd1);
`endif

        // Dwell filtering: 3-cycle glitches never commit; a held 9 lands on the 6th edge
        hold(4'hE, 7'h40, 3);
        hold(4'hE, 7'h79, 3);
        hold(4'hE, 7'h24, 3);
        for (int k = 1; k <= 8; k++) begin
            step(4'hE, 7'h10, 0);
            if (k == 5) check("dwell_before", 32'(digits[3:0]), 32'd5);
            if (k == 6) check("dwell_at", 32'(digits[3:0]), 32'd9);
        end

        // Blink on digit 3, then restore
        for (int i = 0; i < 4; i++) hold(an_sel[i], (i == 3) ? 7'h7F : t0235[i], 8);
        check("blink_blank", 32'(blank[3]), 32'd1);
        check("blink_valid", 32'(digit_valid[3]), 32'd0);
        check("blink_hold", 32'(digits[15:12]), 32'd0);
        for (int i = 0; i < 4; i++) hold(an_sel[i], t0235[i], 8);
        check("unblink_blank", 32'(blank[3]), 32'd0);
        check("unblink_valid", 32'(digit_valid[3]), 32'd1);

        // Illegal anode, clear, illegal segment, clear
        hold(4'b1100, 7'h40, 8);
        check("multi_anode_err", 32'(scan_err), 32'd1);
        check("multi_anode_digits", 32'(digits), 32'h0235);
        hold(4'hF, 7'h7F, 2);
        step(4'hF, 7'h7F, 1);
        check("clr_err", 32'(scan_err), 32'd0);
        hold(4'hE, 7'h55, 8);
        check("bad_seg_err", 32'(scan_err), 32'd1);
        check("bad_seg_valid0", 32'(digit_valid[0]), 32'd0);
        step(4'hF, 7'h7F, 1);

        // Long idle: no frame, no error
        base = fd_cnt;
        hold(4'hF, 7'h7F, 40);
        check("idle_no_fd", 32'(fd_cnt - base), 32'd0);
        check("idle_no_err", 32'(scan_err), 32'd0);

        // Reset after two commits discards the partial frame
        hold(4'hE, 7'h40, 8);
        hold(4'hD, 7'h79, 8);
        do_reset();
        base = fd_cnt;
        for (int i = 0; i < 3; i++) hold(an_sel[i], t0235[i], 8);
        check("post_rst_3commits", 32'(fd_cnt - base), 32'd0);
        hold(an_sel[3], t0235[3], 8);
        check("post_rst_4commits", 32'(fd_cnt - base), 32'd1);

        // Randomized rotations with glitches, blinks, bad patterns, gaps and clr pulses
        for (int r = 0; r < 60; r++) begin
            for (int i = 0; i < 4; i++) begin
                int p, len;
                an = an_sel[i];
                sg = seg_code[$urandom_range(0, 9)];
                p = $urandom_range(0, 19);
                if (p == 0) sg = 7'h7F;
                else if (p == 1) sg = 7'($urandom_range(0, 127));
                else if (p == 2) an = 4'($urandom_range(0, 15));
                len = $urandom_range(2, 9);
                repeat (len) step(an, sg, $urandom_range(0, 15) == 0);
                if ($urandom_range(0, 3) == 0)
                    repeat ($urandom_range(1, 5)) step(4'hF, 7'h7F, $urandom_range(0, 7) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/segment_scan_decoder.md
Name: segment_scan_decoder

Overview:
- Receive-side counterpart of the stopwatch's multiplexed 7-segment display driver.
- Samples the time-multiplexed active-low anode/segment bus and recovers the four displayed BCD digits, plus blank status and a per-frame strobe.
- Used as an on-chip readback/self-check block beside the display path, and as a bench monitor.

Parameters:
- STABLE_CYC, 4: consecutive identical synchronized samples of {anode,segment} needed before a digit is committed. Legal range 2..255.
- CNT_W, 8: width of the dwell counter. Must satisfy 2^CNT_W > STABLE_CYC.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- anode  input  4  active-low digit enables; anode[0]=seconds ones … anode[3]=minutes tens
- segment  input  7  active-low segments, bit order {g,f,e,d,c,b,a}
- clr_err  input  1  synchronous pulse; clears scan_err
- digits  output  16  recovered BCD digits; digit i at [4i+3:4i]
- digit_valid  output  4  digit i holds a decoded numeral from its latest commit
- blank  output  4  latest commit for digit i was all segments off
- frame_done  output  1  one-cycle pulse when all four digits have been committed since the previous pulse
- scan_err  output  1  sticky error flag

Behaviour:
- Reset (async assert, sync release): digits=0, digit_valid=0, blank=0, frame_done=0, scan_err=0, dwell counter=0, seen mask=0. Synchronizer flops reset to all-ones (idle bus).
- Input path: 2-flop synchronizer on all 11 bus bits, then a previous-sample register.
- Dwell counter:
  - When the synchronized sample equals the previous sample, the counter increments and saturates at STABLE_CYC.
  - When the sample differs, the counter returns to 0.
  - A commit fires once, in the cycle the counter reaches STABLE_CYC-1, i.e. after STABLE_CYC equal samples. No re-commit until the bus changes.
- Commit classification by anode:
  - 4'b1111 (idle/blanking gap): no update, no error.
  - Exactly one bit low, index i: decode segment as below; set seen[i].
  - Two or more bits low: set scan_err; no update; seen unchanged.
- Segment decode (active-low hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Numeral match: digits[i]=value, digit_valid[i]=1, blank[i]=0.
  - 7F (all off, the blink phase): blank[i]=1, digit_valid[i]=0, digits[i] holds its old value.
  - Any other pattern: scan_err=1, digit_valid[i]=0, blank[i]=0, digits[i] held.
- Outputs register at the commit edge. Latency from a stable bus change to output update is 2 (sync) + STABLE_CYC cycles.
- Frame:
  - When the seen mask, including the current commit, equals 4'hF, assert frame_done for that cycle and clear seen.
  - Re-committing an already-seen index before completion overwrites the digit and does not pulse.
- Errors: scan_err is sticky.
  - clr_err clears it next edge.
  - If clr_err and a new error occur in the same cycle, the error wins (scan_err stays 1).
- Reset mid-frame discards partial frame state. No frame_done until four fresh commits.

Optional Feature:
- Macro: SEG_BIN_OUT_EN
- Defined:
  - Adds outputs mins[5:0], secs[5:0] (reset 0) and bin_valid (reset 0).
  - One cycle after frame_done: if all four digit_valid=1 and both tens digits ≤5, load secs=10*d1+d0 and mins=10*d3+d2, and set bin_valid=1.
  - Otherwise hold mins/secs and set bin_valid=0. A tens digit >5 also sets scan_err.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Drive the rotation anode=E,D,B,7 with segments 12,30,24,40 ("02:35"), each held 8 cycles, STABLE_CYC=4 → digits=16'h0235, digit_valid=F, frame_done one pulse per rotation. With SEG_BIN_OUT_EN: mins=2, secs=35, bin_valid=1.
- Dwell filtering: change the segment pattern every 3 cycles, STABLE_CYC=4 → no commit, outputs unchanged. Then hold 4 cycles → commit exactly 6 cycles after the change (2 sync + 4).
- Blink: digit 3 shows 7F for one rotation → blank[3]=1, digit_valid[3]=0, digits[15:12] retains its prior value. Next rotation with 40 → blank[3]=0, digit_valid[3]=1.
- Illegal input: anode=4'b1100 stable → scan_err=1, no digit change. Illegal segment 7'h55 on anode E → scan_err=1, digit_valid[0]=0. Pulse clr_err with the bus idle → scan_err=0.
- Idle and reset: anode=F indefinitely → no frame_done, no error. Assert rst_n low mid-rotation after 2 commits → all outputs 0 immediately. After release, frame_done only after 4 new commits.
